// File: rtl/uart_tx_gen.sv
// ----------------------------------------------------------------------------
// uart_tx_gen
//   UART transmitter with a first-word-fall-through TX FIFO. Bytes pushed into
//   the FIFO are serialised as start / 5..8 data (LSB first) / optional parity
//   / 1, 1.5 or 2 stop bits, each bit lasting OVS baud-enable ticks. Supports
//   break generation and CTS flow control.
//
// Parameters
//   OVS        : enable ticks per bit (even, 4..32)
//   FIFO_DEPTH : TX FIFO entries (power of two, 2..256)
//   CNT_W      : width of tf_count
//
// Ports
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   enable     : one-clk baud tick at OVS x baud; the FSM advances only on it
//   lcr        : line control [1:0] len, [2] stop, [3] PE, [4] EP, [5] SP, [6] break
//   tf_push    : write dat_i into the FIFO
//   dat_i      : byte to transmit
//   cts_n      : clear-to-send, active low
//   flow_en    : honour cts_n when high
//   stx_pad_o  : registered serial output
//   tf_count   : FIFO occupancy
//   tf_full    : FIFO holds FIFO_DEPTH entries
//   tf_ovf     : one-clk pulse after a push was dropped because the FIFO was full
//   tx_empty   : FIFO empty and transmitter idle
// ----------------------------------------------------------------------------
module uart_tx_gen #(
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       lcr,
    input  logic             tf_push,
    input  logic [7:0]       dat_i,
    input  logic             cts_n,
    input  logic             flow_en,
    output logic             stx_pad_o,
    output logic [CNT_W-1:0] tf_count,
    output logic             tf_full,
    output logic             tf_ovf,
    output logic             tx_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(2 * OVS);

    // Last tick index of one bit time and of each stop length.
    localparam logic [TW-1:0] LAST_1X  = TW'(OVS - 1);
    localparam logic [TW-1:0] LAST_15X = TW'((3 * OVS) / 2 - 1);
    localparam logic [TW-1:0] LAST_2X  = TW'(2 * OVS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // ------------------------------------------------------------------ FIFO
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             fifo_full;
    logic             push_ok;
    logic             tf_pop;
    logic [7:0]       fifo_head;

    state_e           state_q, state_d;

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_ok   = tf_push && !fifo_full;
    // A full FIFO drops the push even if a pop happens in the same cycle.
    assign tf_pop    = enable && (state_q == ST_LOAD);
    assign fifo_head = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= tf_push && fifo_full;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (tf_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, tf_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------ parity of head
    // Mask off data bits beyond the configured character length.
    logic [7:0] data_mask;
    logic [7:0] masked_head;
    logic       par_calc;

    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        if (gi < 5) begin : g_always
            assign data_mask[gi] = 1'b1;
        end else begin : g_len
            assign data_mask[gi] = ({1'b0, lcr[1:0]} >= 3'(gi - 4));
        end
    end

    assign masked_head = fifo_head & data_mask;
    // {EP,SP}: 00 odd, 10 even, 01 stick 1, 11 stick 0.
    assign par_calc = lcr[5] ? ~lcr[4] : (lcr[4] ? ^masked_head : ~^masked_head);

    logic lcr_unused;
    assign lcr_unused = lcr[7];

    // ------------------------------------------------------------------- FSM
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [5:0]    lcr_q, lcr_d;
    logic          line_q, line_d;
    logic          pad_q, pad_d;

    logic [TW-1:0] tick_last;
    logic          tick_done;
    logic [2:0]    bit_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            lcr_q   <= '0;
            line_q  <= 1'b1;
            pad_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            lcr_q   <= lcr_d;
            line_q  <= line_d;
            pad_q   <= pad_d;
        end
    end

    // Next-state logic; the frame uses the lcr copy taken in LOAD.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        lcr_d    = lcr_q;
        bit_last = {1'b0, lcr_q[1:0]} + 3'd4;

        if (state_q == ST_STOP) begin
            if (!lcr_q[2]) begin
                tick_last = LAST_1X;
            end else if (lcr_q[1:0] == 2'b00) begin
                tick_last = LAST_15X;
            end else begin
                tick_last = LAST_2X;
            end
        end else begin
            tick_last = LAST_1X;
        end
        tick_done = (tick_q == tick_last);

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if ((count_q != '0) && (!flow_en || !cts_n)) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_d = fifo_head;
                    par_d   = par_calc;
                    lcr_d   = lcr[5:0];
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
                ST_START: begin
                    if (tick_done) begin
                        tick_d  = '0;
                        state_d = ST_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_done) begin
                        tick_d = '0;
                        if (bit_q == bit_last) begin
                            state_d = lcr_q[3] ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (tick_done) begin
                        tick_d  = '0;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_done) begin
                        tick_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: the line takes the value of the state being entered, so
    // it changes on the same enable edge as the state. Break overrides the
    // pad on any clock edge while the line value keeps tracking the FSM.
    always_comb begin
        line_d = line_q;
        if (enable) begin
            case (state_d)
                ST_START:  line_d = 1'b0;
                ST_DATA:   line_d = shift_d[0];
                ST_PARITY: line_d = par_d;
                default:   line_d = 1'b1;
            endcase
        end
        pad_d = lcr[6] ? 1'b0 : line_d;
    end

    assign stx_pad_o = pad_q;
    assign tf_count  = count_q;
    assign tf_full   = fifo_full;
    assign tf_ovf    = ovf_q;
    assign tx_empty  = (count_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_gen.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_gen
//   Directed bench for uart_tx_gen (OVS=16, FIFO_DEPTH=4, enable held high
//   except where noted, so one tick equals one clk). A table of frame
//   formats with hand-computed parity / stop lengths is swept in a loop,
//   followed by hand-written sequences for back-to-back gaps, CTS flow
//   control, FIFO overflow and wrap, break and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_uart_tx_gen;

    localparam int OVS   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          enable  = 1'b1;
    logic [7:0]    lcr     = 8'h03;
    logic          tf_push = 1'b0;
    logic [7:0]    dat_i   = 8'h00;
    logic          cts_n   = 1'b0;
    logic          flow_en = 1'b0;
    logic          stx_pad_o;
    logic [CW-1:0] tf_count;
    logic          tf_full;
    logic          tf_ovf;
    logic          tx_empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_gen #(
        .OVS        (OVS),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .lcr       (lcr),
        .tf_push   (tf_push),
        .dat_i     (dat_i),
        .cts_n     (cts_n),
        .flow_en   (flow_en),
        .stx_pad_o (stx_pad_o),
        .tf_count  (tf_count),
        .tf_full   (tf_full),
        .tf_ovf    (tf_ovf),
        .tx_empty  (tx_empty)
    );

    typedef struct {
        logic [7:0] lcr;
        logic [7:0] data;
        int         nbits;
        int         par_en;
        logic       par;
        int         stop;
    } vec_t;

    typedef struct {
        logic [7:0] lcr;
        int         low;
        int         high;
    } gap_t;

    vec_t vecs[10];
    gap_t gaps[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (tx_empty !== 1'b1 && c < 3000) begin
            tick();
            c++;
        end
        check("idle_reached", 32'(tx_empty), 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        dat_i   = b;
        tf_push = 1'b1;
        tick();
        tf_push = 1'b0;
    endtask

    task automatic wait_fall(output int lat);
        lat = 0;
        while (stx_pad_o !== 1'b0 && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    // Receive one 8N1 frame, sampling mid-bit, and check its stop bit.
    task automatic rx_byte(output logic [7:0] b);
        int lat;
        b = '0;
        wait_fall(lat);
        check("rx_start_seen", 32'(lat < 400), 32'd1);
        repeat (24) tick();
        for (int i = 0; i < 8; i++) begin
            b[i] = stx_pad_o;
            repeat (16) tick();
        end
        check("rx_stop_bit", 32'(stx_pad_o), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat, k, bidx, frame_bits;
        logic exp_bit;
        wait_idle();
        lcr = v.lcr;
        push_byte(v.data);
        lat = 1;
        while (stx_pad_o !== 1'b0 && lat < 50) begin
            tick();
            lat++;
        end
        // Push edge plus IDLE->LOAD plus LOAD->START.
        check($sformatf("v%0d_start_latency", idx), 32'(lat), 32'd3);
        frame_bits = 1 + v.nbits + v.par_en;
        k = 0;
        while (tx_empty !== 1'b1 && k < 1000) begin
            if (k % 16 == 8) begin
                bidx = k / 16;
                if (bidx == 0) exp_bit = 1'b0;
                else if (bidx <= v.nbits) exp_bit = v.data[3'(bidx - 1)];
                else if (bidx < frame_bits) exp_bit = v.par;
                else exp_bit = 1'b1;
                check($sformatf("v%0d_bit%0d", idx, bidx), 32'(stx_pad_o), 32'(exp_bit));
            end
            tick();
            k++;
        end
        check($sformatf("v%0d_frame_len", idx), 32'(k), 32'(frame_bits * 16 + v.stop));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, lo, hi;
        logic        seen_low;
        logic [7:0]  rb;
        logic [7:0]  exp_bytes [6];

        //            lcr    data   N  PE par stop
        vecs[0] = '{8'h03, 8'hA5, 8, 0, 1'b0, 16};
        vecs[1] = '{8'h1A, 8'h41, 7, 1, 1'b0, 16};
        vecs[2] = '{8'h0A, 8'h41, 7, 1, 1'b1, 16};
        vecs[3] = '{8'h2A, 8'h41, 7, 1, 1'b1, 16};
        vecs[4] = '{8'h04, 8'h15, 5, 0, 1'b0, 24};
        vecs[5] = '{8'h07, 8'h3C, 8, 0, 1'b0, 32};
        vecs[6] = '{8'h19, 8'h83, 6, 1, 1'b0, 16};
        vecs[7] = '{8'h38, 8'h1F, 5, 1, 1'b0, 16};
        vecs[8] = '{8'h0C, 8'hE3, 5, 1, 1'b1, 24};
        vecs[9] = '{8'h0F, 8'hA5, 8, 1, 1'b1, 32};

        //            lcr    low(frame) high(stop+2)
        gaps[0] = '{8'h07, 144, 34};
        gaps[1] = '{8'h04,  96, 26};
        gaps[2] = '{8'h03, 144, 18};

        exp_bytes[0] = 8'h11;
        exp_bytes[1] = 8'h22;
        exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h44;
        exp_bytes[4] = 8'h5A;
        exp_bytes[5] = 8'hC3;

        // Reset state
        repeat (3) tick();
        check("rst_stx", 32'(stx_pad_o), 32'd1);
        check("rst_count", 32'(tf_count), 32'd0);
        check("rst_full", 32'(tf_full), 32'd0);
        check("rst_ovf", 32'(tf_ovf), 32'd0);
        check("rst_empty", 32'(tx_empty), 32'd1);
        rst_n = 1'b1;
        tick();

        // Frame formats
        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back frames; second push lands on the LOAD (pop) cycle
        for (int i = 0; i < 3; i++) begin
            wait_idle();
            lcr = gaps[i].lcr;
            push_byte(8'h00);
            tick();
            push_byte(8'h00);
            check($sformatf("g%0d_fall", i), 32'(stx_pad_o), 32'd0);
            check($sformatf("g%0d_push_pop_count", i), 32'(tf_count), 32'd1);
            lo = 0;
            while (stx_pad_o === 1'b0 && lo < 400) begin
                tick();
                lo++;
            end
            check($sformatf("g%0d_low", i), 32'(lo), 32'(gaps[i].low));
            hi = 0;
            while (stx_pad_o === 1'b1 && hi < 400) begin
                tick();
                hi++;
            end
            check($sformatf("g%0d_mark_gap", i), 32'(hi), 32'(gaps[i].high));
        end

        // CTS flow control
        wait_idle();
        lcr     = 8'h03;
        flow_en = 1'b1;
        cts_n   = 1'b1;
        push_byte(8'h55);
        push_byte(8'hAA);
        seen_low = 1'b0;
        repeat (50) begin
            tick();
            if (stx_pad_o !== 1'b1) seen_low = 1'b1;
        end
        check("cts_held_line", 32'(seen_low), 32'd0);
        check("cts_held_count", 32'(tf_count), 32'd2);
        cts_n = 1'b0;
        lat = 0;
        while (stx_pad_o !== 1'b0 && lat < 50) begin
            tick();
            lat++;
        end
        check("cts_start_latency", 32'(lat), 32'd2);
        seen_low = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k == 40) cts_n = 1'b1;
            if (k == 136) check("cts_frame_continues", 32'(stx_pad_o), 32'd0);
            if (k == 152) check("cts_frame_stop", 32'(stx_pad_o), 32'd1);
            if (k > 160 && stx_pad_o !== 1'b1) seen_low = 1'b1;
        end
        check("cts_second_held", 32'(seen_low), 32'd0);
        check("cts_second_count", 32'(tf_count), 32'd1);
        cts_n = 1'b0;
        wait_idle();
        flow_en = 1'b0;

        // Overflow with no ticks, then drain in order with pointer wrap
        enable = 1'b0;
        lcr    = 8'h03;
        for (int i = 0; i < 4; i++) begin
            push_byte(exp_bytes[i]);
        end
        check("ovf_full", 32'(tf_full), 32'd1);
        check("ovf_count4", 32'(tf_count), 32'd4);
        check("ovf_no_pulse_yet", 32'(tf_ovf), 32'd0);
        push_byte(8'hEE);
        check("ovf_pulse", 32'(tf_ovf), 32'd1);
        check("ovf_count_held", 32'(tf_count), 32'd4);
        tick();
        check("ovf_pulse_one_clk", 32'(tf_ovf), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_byte(rb);
            check($sformatf("ovf_rx%0d", i), 32'(rb), 32'(exp_bytes[i]));
        end
        wait_idle();
        push_byte(exp_bytes[4]);
        push_byte(exp_bytes[5]);
        for (int i = 4; i < 6; i++) begin
            rx_byte(rb);
            check($sformatf("wrap_rx%0d", i), 32'(rb), 32'(exp_bytes[i]));
        end

        // Break mid-frame
        wait_idle();
        lcr = 8'h03;
        push_byte(8'hFF);
        wait_fall(lat);
        repeat (40) tick();
        check("brk_before", 32'(stx_pad_o), 32'd1);
        lcr = 8'h43;
        tick();
        check("brk_on", 32'(stx_pad_o), 32'd0);
        repeat (10) tick();
        check("brk_hold", 32'(stx_pad_o), 32'd0);
        lcr = 8'h03;
        tick();
        check("brk_off", 32'(stx_pad_o), 32'd1);
        wait_idle();
        check("brk_consumed", 32'(tf_count), 32'd0);

        // Asynchronous reset mid-DATA
        lcr = 8'h03;
        push_byte(8'h00);
        push_byte(8'h00);
        wait_fall(lat);
        repeat (50) tick();
        check("rstm_in_data", 32'(stx_pad_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rstm_stx", 32'(stx_pad_o), 32'd1);
        check("rstm_count", 32'(tf_count), 32'd0);
        check("rstm_empty", 32'(tx_empty), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        seen_low = 1'b0;
        repeat (40) begin
            tick();
            if (stx_pad_o !== 1'b1) seen_low = 1'b1;
        end
        check("rstm_no_frame", 32'(seen_low), 32'd0);
        check("rstm_still_empty", 32'(tx_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
